// File: rtl/axis_pkt_fifo_pkg.sv
// Package: axis_pkg
//
// Shared definitions for the AXI4-Stream packet FIFO.
//  - Default field widths used by the FIFO and its interface.
//  - Field selector enum plus helpers that give the total width of a packed
//    beat word and the bit offset of each field inside it.
//  - Packed beat layout, LSB first:
//      tdata | tstrb | tkeep | tlast | tid | tdest | tuser

package axis_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 1;
  localparam int DEF_DEST_WIDTH = 1;
  localparam int DEF_USER_WIDTH = 1;
  localparam int DEF_DEPTH      = 16;

  typedef enum logic [2:0] {
    FLD_DATA,
    FLD_STRB,
    FLD_KEEP,
    FLD_LAST,
    FLD_ID,
    FLD_DEST,
    FLD_USER
  } axis_field_e;

  // Total width of one packed beat.
  function automatic int axis_beat_width(int data_w, int id_w, int dest_w, int user_w);
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

  // Bit offset of a field inside the packed beat word.
  function automatic int axis_field_ofs(axis_field_e fld, int data_w, int id_w, int dest_w);
    int strb_w;
    strb_w = data_w / 8;
    case (fld)
      FLD_DATA: return 0;
      FLD_STRB: return data_w;
      FLD_KEEP: return data_w + strb_w;
      FLD_LAST: return data_w + 2 * strb_w;
      FLD_ID:   return data_w + 2 * strb_w + 1;
      FLD_DEST: return data_w + 2 * strb_w + 1 + id_w;
      default:  return data_w + 2 * strb_w + 1 + id_w + dest_w;
    endcase
  endfunction

  // Field offsets for the default widths.
  localparam int DEF_STRB_OFS = axis_field_ofs(FLD_STRB, DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);
  localparam int DEF_KEEP_OFS = axis_field_ofs(FLD_KEEP, DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);
  localparam int DEF_LAST_OFS = axis_field_ofs(FLD_LAST, DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);
  localparam int DEF_ID_OFS   = axis_field_ofs(FLD_ID,   DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);
  localparam int DEF_DEST_OFS = axis_field_ofs(FLD_DEST, DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);
  localparam int DEF_USER_OFS = axis_field_ofs(FLD_USER, DEF_DATA_WIDTH, DEF_ID_WIDTH, DEF_DEST_WIDTH);

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// Interface: axis_if
//
// One AXI4-Stream link.
//  master modport: drives tvalid and the payload, receives tready.
//  slave  modport: receives tvalid and the payload, drives tready.
//  Payload: tdata[DATA_WIDTH], tstrb/tkeep[DATA_WIDTH/8], tlast,
//           tid[ID_WIDTH], tdest[DEST_WIDTH], tuser[USER_WIDTH].

interface axis_if #(
  parameter int DATA_WIDTH = axis_pkg::DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = axis_pkg::DEF_ID_WIDTH,
  parameter int DEST_WIDTH = axis_pkg::DEF_DEST_WIDTH,
  parameter int USER_WIDTH = axis_pkg::DEF_USER_WIDTH
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic [STRB_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_pkt_fifo_ram.sv
// Module: axis_fifo_ram
//
// Simple dual-port storage for the packet FIFO: DEPTH words of WIDTH bits.
//  aclk     in   clock; write on rising edge
//  wr_en    in   write strobe
//  wr_addr  in   write address
//  wr_data  in   write word
//  rd_addr  in   read address
//  rd_data  out  asynchronous read of mem[rd_addr]

module axis_fifo_ram #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the top-level pointers and occupancy decide
  // which words are live, so stale contents are never presented.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Module: axis_pkt_fifo
//
// Parametrised AXI4-Stream FIFO, cut-through or store-and-forward.
//  aclk          in   clock
//  arstn         in   asynchronous active-low reset
//  s_axis        slave modport   upstream link (tready is registered)
//  m_axis        master modport  downstream link (payload read from storage)
//  occupancy     out  beats currently stored
//  pkt_count     out  complete packets stored (tlast beats held)
//  oversize_err  out  sticky: a store-and-forward packet did not fit in DEPTH
//
// In store-and-forward mode a packet is presented only after its tlast beat
// is stored. A packet larger than the FIFO would deadlock that rule, so when
// the FIFO fills without a complete packet the release flag is raised and the
// FIFO drains cut-through until that packet's tlast beat leaves.

module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int DEST_WIDTH  = DEF_DEST_WIDTH,
  parameter int USER_WIDTH  = DEF_USER_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PACKET_MODE = 0
) (
  input  logic                   aclk,
  input  logic                   arstn,
  axis_if.slave                  s_axis,
  axis_if.master                 m_axis,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   oversize_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = AW + 1;
  localparam int BEAT_W     = axis_beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int STRB_OFS   = axis_field_ofs(FLD_STRB, DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
  localparam int KEEP_OFS   = axis_field_ofs(FLD_KEEP, DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
  localparam int LAST_OFS   = axis_field_ofs(FLD_LAST, DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
  localparam int ID_OFS     = axis_field_ofs(FLD_ID,   DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
  localparam int DEST_OFS   = axis_field_ofs(FLD_DEST, DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
  localparam int USER_OFS   = axis_field_ofs(FLD_USER, DATA_WIDTH, ID_WIDTH, DEST_WIDTH);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occ_q, occ_next;
  logic [CW-1:0]     pkt_q, pkt_next;
  logic              s_ready_q;
  logic              release_q;
  logic              err_q;
  logic              push, pop, push_last, pop_last;
  logic              data_avail, oversize_set;
  logic [BEAT_W-1:0] wr_beat, rd_beat;

  // Pack / unpack; the concatenation order matches the package offsets.
  assign wr_beat = {s_axis.tuser, s_axis.tdest, s_axis.tid, s_axis.tlast,
                    s_axis.tkeep, s_axis.tstrb, s_axis.tdata};

  assign m_axis.tdata = rd_beat[DATA_WIDTH-1:0];
  assign m_axis.tstrb = rd_beat[STRB_OFS +: STRB_WIDTH];
  assign m_axis.tkeep = rd_beat[KEEP_OFS +: STRB_WIDTH];
  assign m_axis.tlast = rd_beat[LAST_OFS];
  assign m_axis.tid   = rd_beat[ID_OFS   +: ID_WIDTH];
  assign m_axis.tdest = rd_beat[DEST_OFS +: DEST_WIDTH];
  assign m_axis.tuser = rd_beat[USER_OFS +: USER_WIDTH];

  axis_fifo_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_beat),
    .rd_addr (rd_ptr),
    .rd_data (rd_beat)
  );

  // Handshakes.
  assign s_axis.tready = s_ready_q;
  assign data_avail    = (occ_q != '0);
  assign m_axis.tvalid = (PACKET_MODE != 0) ? (data_avail && ((pkt_q != '0) || release_q))
                                            : data_avail;

  assign push      = s_axis.tvalid && s_ready_q;
  assign pop       = m_axis.tvalid && m_axis.tready;
  assign push_last = push && s_axis.tlast;
  assign pop_last  = pop && rd_beat[LAST_OFS];

  // Full with no complete packet stored: store-and-forward can never release.
  assign oversize_set = (PACKET_MODE != 0) && (occ_q == FULL) && (pkt_q == '0);

  // NOTE: every signal assigned in always_comb gets its default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    occ_next = occ_q;
    pkt_next = pkt_q;
    if (push && !pop)      occ_next = occ_q + CW'(1);
    else if (pop && !push) occ_next = occ_q - CW'(1);
    if (push_last && !pop_last)      pkt_next = pkt_q + CW'(1);
    else if (pop_last && !push_last) pkt_next = pkt_q - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ_q     <= '0;
      pkt_q     <= '0;
      s_ready_q <= 1'b0;
      release_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ_q <= occ_next;
      pkt_q <= pkt_next;
      // No full-bypass: a pop while full only reopens tready next cycle.
      s_ready_q <= (occ_next < FULL);
      if (oversize_set) begin
        err_q     <= 1'b1;
        release_q <= 1'b1;
      end else if (release_q && pop_last) begin
        release_q <= 1'b0;
      end
    end
  end

  assign occupancy    = occ_q;
  assign pkt_count    = pkt_q;
  assign oversize_err = err_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Testbench: tb_axis_pkt_fifo
//
// Two FIFO instances share clock and reset:
//  index 0: cut-through,       DEPTH=16
//  index 1: store-and-forward, DEPTH=8
// Inputs change 1 ns after the rising edge; handshakes and DUT outputs are
// sampled on the falling edge. A per-instance scoreboard queue receives each
// accepted beat and is compared against each beat the DUT hands out.

module tb_axis_pkt_fifo;

  typedef struct packed {
    logic [0:0]  user;
    logic [0:0]  dest;
    logic [0:0]  id;
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic       v;
    logic       mr;
    logic [4:0] exp_occ;
    logic       exp_sready;
    logic       exp_mvalid;
  } vec_t;

  logic aclk  = 1'b0;
  logic arstn = 1'b0;
  always #5 aclk = ~aclk;

  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) ct_s ();
  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) ct_m ();
  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) pm_s ();
  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) pm_m ();

  logic [4:0] ct_occ, ct_pkt;
  logic [3:0] pm_occ, pm_pkt;
  logic       ct_err, pm_err;

  axis_pkt_fifo #(.DEPTH(16), .PACKET_MODE(0)) u_ct (
    .aclk         (aclk),
    .arstn        (arstn),
    .s_axis       (ct_s),
    .m_axis       (ct_m),
    .occupancy    (ct_occ),
    .pkt_count    (ct_pkt),
    .oversize_err (ct_err)
  );

  axis_pkt_fifo #(.DEPTH(8), .PACKET_MODE(1)) u_pm (
    .aclk         (aclk),
    .arstn        (arstn),
    .s_axis       (pm_s),
    .m_axis       (pm_m),
    .occupancy    (pm_occ),
    .pkt_count    (pm_pkt),
    .oversize_err (pm_err)
  );

  // Stimulus and observation, indexed by instance.
  logic  drv_valid  [2];
  logic  drv_mready [2];
  beat_t drv_beat   [2];
  logic  s_ready    [2];
  logic  m_valid    [2];
  beat_t m_beat     [2];
  logic [4:0] occ   [2];
  logic [4:0] pkt   [2];
  logic  err        [2];

  assign ct_s.tvalid = drv_valid[0];
  assign ct_s.tdata  = drv_beat[0].data;
  assign ct_s.tstrb  = drv_beat[0].strb;
  assign ct_s.tkeep  = drv_beat[0].keep;
  assign ct_s.tlast  = drv_beat[0].last;
  assign ct_s.tid    = drv_beat[0].id;
  assign ct_s.tdest  = drv_beat[0].dest;
  assign ct_s.tuser  = drv_beat[0].user;
  assign ct_m.tready = drv_mready[0];

  assign pm_s.tvalid = drv_valid[1];
  assign pm_s.tdata  = drv_beat[1].data;
  assign pm_s.tstrb  = drv_beat[1].strb;
  assign pm_s.tkeep  = drv_beat[1].keep;
  assign pm_s.tlast  = drv_beat[1].last;
  assign pm_s.tid    = drv_beat[1].id;
  assign pm_s.tdest  = drv_beat[1].dest;
  assign pm_s.tuser  = drv_beat[1].user;
  assign pm_m.tready = drv_mready[1];

  assign s_ready[0] = ct_s.tready;
  assign s_ready[1] = pm_s.tready;
  assign m_valid[0] = ct_m.tvalid;
  assign m_valid[1] = pm_m.tvalid;
  assign m_beat[0]  = {ct_m.tuser, ct_m.tdest, ct_m.tid, ct_m.tlast, ct_m.tkeep, ct_m.tstrb, ct_m.tdata};
  assign m_beat[1]  = {pm_m.tuser, pm_m.tdest, pm_m.tid, pm_m.tlast, pm_m.tkeep, pm_m.tstrb, pm_m.tdata};
  assign occ[0]     = ct_occ;
  assign occ[1]     = {1'b0, pm_occ};
  assign pkt[0]     = ct_pkt;
  assign pkt[1]     = {1'b0, pm_pkt};
  assign err[0]     = ct_err;
  assign err[1]     = pm_err;

  int    n_pass  = 0;
  int    n_total = 0;
  logic  pending [2];
  int    n_acc   [2];
  beat_t sb0 [$];
  beat_t sb1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic beat_t mk_beat(input logic [31:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.strb = data[3:0];
    b.keep = data[7:4];
    b.last = last;
    b.id   = data[8];
    b.dest = data[9];
    b.user = data[10];
    return b;
  endfunction

  function automatic int model_occ(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic int model_pkt(input int d);
    int n = 0;
    if (d == 0) begin
      foreach (sb0[i]) if (sb0[i].last) n++;
    end else begin
      foreach (sb1[i]) if (sb1[i].last) n++;
    end
    return n;
  endfunction

  // Scoreboard: compare popped beats first (they are always older), then
  // record the beat accepted at the coming edge.
  always @(negedge aclk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d] && drv_mready[d]) begin
        if (model_occ(d) == 0) begin
          check((d == 0) ? "ct_stray_beat" : "pm_stray_beat", 64'(m_valid[d]), 64'd0);
        end else begin
          beat_t e_beat;
          if (d == 0) e_beat = sb0.pop_front();
          else        e_beat = sb1.pop_front();
          check((d == 0) ? "ct_sb_beat" : "pm_sb_beat", 64'(m_beat[d]), 64'(e_beat));
        end
      end
      if (drv_valid[d] && s_ready[d]) begin
        if (d == 0) sb0.push_back(drv_beat[d]);
        else        sb1.push_back(drv_beat[d]);
      end
    end
  end

  // One clock of stimulus on instance d. A beat offered but not accepted is
  // held (valid and payload unchanged) on the next call.
  task automatic step(input int d, input logic v_in, input logic last,
                      input logic mr, input logic [31:0] data);
    logic v;
    logic acc;
    v = v_in | pending[d];
    drv_valid[d]  = v;
    drv_mready[d] = mr;
    if (!pending[d]) drv_beat[d] = mk_beat(data, last);
    @(negedge aclk);
    acc = v && s_ready[d];
    @(posedge aclk);
    #1;
    pending[d] = v && !acc;
    if (acc) n_acc[d]++;
    check((d == 0) ? "ct_occ_model" : "pm_occ_model", 64'(occ[d]), 64'(model_occ(d)));
    check((d == 0) ? "ct_pkt_model" : "pm_pkt_model", 64'(pkt[d]), 64'(model_pkt(d)));
  endtask

  task automatic drain(input int d);
    int n = 0;
    while ((occ[d] != 5'd0 || pending[d]) && n < 200) begin
      step(d, 1'b0, 1'b0, 1'b1, 32'd0);
      n++;
    end
    check((d == 0) ? "ct_drain_empty" : "pm_drain_empty", 64'(occ[d]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [18];
    int   base;
    int   cyc;
    logic [31:0] data;

    for (int d = 0; d < 2; d++) begin
      drv_valid[d]  = 1'b0;
      drv_mready[d] = 1'b0;
      drv_beat[d]   = '0;
      pending[d]    = 1'b0;
      n_acc[d]      = 0;
    end

    // Fill/stall table for the cut-through instance: 16 pushes with the
    // consumer stalled, one pop while full, then the held beat goes in.
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 5'(i + 1), (i < 15), 1'b1};
    tbl[16] = '{1'b1, 1'b1, 5'd15, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 5'd16, 1'b0, 1'b1};

    // Reset state.
    repeat (2) @(posedge aclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_s_ready",  64'(s_ready[d]), 64'd0);
      check("rst_m_valid",  64'(m_valid[d]), 64'd0);
      check("rst_occ",      64'(occ[d]),     64'd0);
      check("rst_pkt",      64'(pkt[d]),     64'd0);
      check("rst_err",      64'(err[d]),     64'd0);
    end
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    check("ct_ready_after_rst", 64'(s_ready[0]), 64'd1);
    check("pm_ready_after_rst", 64'(s_ready[1]), 64'd1);

    // Cut-through latency, fill to DEPTH, no full-bypass.
    for (int i = 0; i < 18; i++) begin
      data = (i == 0) ? 32'hA5A5_A5A5 : 32'h1000_0000 + 32'(i);
      step(0, tbl[i].v, 1'b0, tbl[i].mr, data);
      check("tbl_occ",     64'(occ[0]),     64'(tbl[i].exp_occ));
      check("tbl_s_ready", 64'(s_ready[0]), 64'(tbl[i].exp_sready));
      check("tbl_m_valid", 64'(m_valid[0]), 64'(tbl[i].exp_mvalid));
      if (i == 0) check("first_tdata", 64'(m_beat[0].data), 64'hA5A5_A5A5);
    end
    drain(0);

    // Store-and-forward: nothing presented until the tlast beat is stored.
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, (i == 3), 1'b1, 32'h2000_0000 + 32'(i));
      check("sf_m_valid_fill", 64'(m_valid[1]), 64'(i == 3));
    end
    check("sf_pkt_one", 64'(pkt[1]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b0, 1'b0, 1'b1, 32'd0);
      check("sf_m_valid_drain", 64'(m_valid[1]), 64'(i < 3));
      check("sf_pkt_drain",     64'(pkt[1]),     64'(i < 3));
    end

    // Oversize packet on the DEPTH=8 store-and-forward instance.
    base = n_acc[1];
    for (int i = 0; i < 8; i++) begin
      step(1, 1'b1, 1'b0, 1'b1, 32'h3000_0000 + 32'(i));
      check("ovs_m_valid_fill", 64'(m_valid[1]), 64'd0);
    end
    check("ovs_full_occ",     64'(occ[1]),     64'd8);
    check("ovs_full_s_ready", 64'(s_ready[1]), 64'd0);
    check("ovs_err_not_yet",  64'(err[1]),     64'd0);
    step(1, 1'b1, 1'b0, 1'b1, 32'h3000_0008);
    check("ovs_err_set",      64'(err[1]),     64'd1);
    check("ovs_release",      64'(m_valid[1]), 64'd1);
    cyc = 0;
    while ((n_acc[1] - base) < 11 && cyc < 200) begin
      step(1, 1'b1, ((n_acc[1] - base) == 10), 1'b1, 32'h3000_0000 + 32'(n_acc[1] - base));
      cyc++;
    end
    check("ovs_all_accepted", 64'(n_acc[1] - base), 64'd11);
    drain(1);
    check("ovs_err_sticky",   64'(err[1]), 64'd1);
    // Release must be clear again: a new partial packet is held back.
    step(1, 1'b1, 1'b0, 1'b1, 32'h3100_0000);
    check("ovs_rel_clr_0", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b0, 1'b1, 32'h3100_0001);
    check("ovs_rel_clr_1", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, 1'b1, 32'h3100_0002);
    check("ovs_next_pkt",  64'(m_valid[1]), 64'd1);
    drain(1);
    check("ovs_err_still", 64'(err[1]), 64'd1);

    // Random traffic on the cut-through instance.
    base = n_acc[0];
    cyc  = 0;
    while (((n_acc[0] - base) < 10000 || occ[0] != 5'd0) && cyc < 60000) begin
      step(0, ((n_acc[0] - base) < 10000) ? 1'($urandom_range(0, 1)) : 1'b0,
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom());
      check("rnd_occ_le_depth", 64'(occ[0] <= 5'd16), 64'd1);
      cyc++;
    end
    check("rnd_beats",     64'(n_acc[0] - base), 64'd10000);
    check("rnd_empty",     64'(occ[0]),          64'd0);
    check("rnd_pkt_zero",  64'(pkt[0]),          64'd0);
    check("ct_err_tied",   64'(err[0]),          64'd0);

    // Reset with a partial packet stored.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 32'h4000_0000 + 32'(i));
    check("mid_occ_five", 64'(occ[0]), 64'd5);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    #2;
    arstn = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid[0]), 64'd0);
    check("mid_rst_occ",     64'(occ[0]),     64'd0);
    check("mid_rst_s_ready", 64'(s_ready[0]), 64'd0);
    check("mid_rst_pm_err",  64'(err[1]),     64'd0);
    sb0.delete();
    sb1.delete();
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_s_ready", 64'(s_ready[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b0, 1'b0, 1'b1, 32'd0);
      check("post_rst_no_stale", 64'(m_valid[0]), 64'd0);
    end
    step(0, 1'b1, 1'b1, 1'b1, 32'h5000_0001);
    check("post_rst_new_beat", 64'(m_valid[0]), 64'd1);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
